// File: rtl/div_pkg.sv
// Shared types and constants for the div16_nr non-restoring divider.
// No logic; imported by the divider top and its add/sub stage users.
package div_pkg;

  localparam int DIV_WIDTH = 16;
  localparam int CNT_W     = $clog2(DIV_WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    FIX,
    DONE
  } state_t;

endpackage

// File: rtl/addsub17.sv
// Combinational add/subtract stage: s = sub ? x - y : x + y (two's complement, carry out dropped).
// Zero latency; no flow control.
module addsub17 #(
  parameter int N = 17
) (
  input  logic         sub,
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  output logic [N-1:0] s
);

  logic [N-1:0] y_eff;

  assign y_eff = y ^ {N{sub}};
  assign s     = x + y_eff + {{(N-1){1'b0}}, sub};

endmodule

// File: rtl/div16_nr.sv
// Sequential non-restoring divider, one quotient bit per clock; ready 18 cycles after start (1 for b==0).
// start is ignored while busy; DIV16_SIGNED_EN adds a sgn input for signed division.
module div16_nr
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
`ifdef DIV16_SIGNED_EN
  input  logic             sgn,
`endif
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             busy,
  output logic             ready,
  output logic             dz
);

  state_t state, state_nxt;

  logic [WIDTH:0]     rem;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   dvs;
  logic [CNT_W-1:0]   cnt;
  logic               neg_q;
  logic               neg_r;

  logic               load_run;
  logic               load_zero;
  logic               iter_en;
  logic               fix_en;

  logic               sgn_in;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;

  logic               as_sub;
  logic [WIDTH:0]     as_x;
  logic [WIDTH:0]     as_y;
  logic [WIDTH:0]     as_s;

  logic [WIDTH:0]     rem_fix;
  logic [WIDTH-1:0]   q_fix;
  logic [WIDTH-1:0]   r_fix;

`ifdef DIV16_SIGNED_EN
  assign sgn_in = sgn;
`else
  assign sgn_in = 1'b0;
`endif

  // Signed mode divides magnitudes; the signs are reapplied in FIX.
  assign a_neg = sgn_in & a[WIDTH-1];
  assign b_neg = sgn_in & b[WIDTH-1];
  assign a_mag = a_neg ? (~a + WIDTH'(1)) : a;
  assign b_mag = b_neg ? (~b + WIDTH'(1)) : b;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    load_run  = 1'b0;
    load_zero = 1'b0;
    iter_en   = 1'b0;
    fix_en    = 1'b0;
    case (state)
      IDLE, DONE: begin
        state_nxt = IDLE;
        if (start) begin
          if (b == '0) begin
            load_zero = 1'b1;
            state_nxt = DONE;
          end else begin
            load_run  = 1'b1;
            state_nxt = ITER;
          end
        end
      end
      ITER: begin
        iter_en = 1'b1;
        if (cnt == CNT_W'(WIDTH - 1)) begin
          state_nxt = FIX;
        end
      end
      FIX: begin
        fix_en    = 1'b1;
        state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // One add/sub stage serves both the iteration step and the final correction.
  always_comb begin
    as_sub = 1'b0;
    as_x   = rem;
    as_y   = {1'b0, dvs};
    if (state == ITER) begin
      as_x   = {rem[WIDTH-1:0], quo[WIDTH-1]};
      as_sub = ~rem[WIDTH];
    end
  end

  addsub17 #(.N(WIDTH + 1)) u_addsub (
    .sub (as_sub),
    .x   (as_x),
    .y   (as_y),
    .s   (as_s)
  );

  assign rem_fix = rem[WIDTH] ? as_s : rem;
  assign q_fix   = neg_q ? (~quo + WIDTH'(1)) : quo;
  assign r_fix   = neg_r ? (~rem_fix[WIDTH-1:0] + WIDTH'(1)) : rem_fix[WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      rem   <= '0;
      quo   <= '0;
      dvs   <= '0;
      cnt   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      q     <= '0;
      r     <= '0;
      dz    <= 1'b0;
    end else begin
      if (load_run) begin
        rem   <= '0;
        quo   <= a_mag;
        dvs   <= b_mag;
        cnt   <= '0;
        neg_q <= a_neg ^ b_neg;
        neg_r <= a_neg;
      end
      if (load_zero) begin
        q  <= '1;
        r  <= a;
        dz <= 1'b1;
      end
      if (iter_en) begin
        rem <= as_s;
        quo <= {quo[WIDTH-2:0], ~as_s[WIDTH]};
        cnt <= cnt + CNT_W'(1);
      end
      if (fix_en) begin
        q  <= q_fix;
        r  <= r_fix;
        dz <= 1'b0;
      end
    end
  end

  assign busy  = (state == ITER) || (state == FIX);
  assign ready = (state == DONE);

endmodule

// File: tb/tb_div16_nr.sv
// Bench for div16_nr: expected results are queued at each accepted start and checked on ready.
module tb_div16_nr;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        sgn;
  logic [15:0] a;
  logic [15:0] b;
  logic [15:0] q;
  logic [15:0] r;
  logic        busy;
  logic        ready;
  logic        dz;

  int cyc    = 0;
  int n_run  = 0;
  int n_fail = 0;

  typedef struct {
    logic [15:0] q;
    logic [15:0] r;
    logic        dz;
    int          due;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  div16_nr dut (
    .clk   (clk),
    .rst   (rst),
`ifdef DIV16_SIGNED_EN
    .sgn   (sgn),
`endif
    .start (start),
    .a     (a),
    .b     (b),
    .q     (q),
    .r     (r),
    .busy  (busy),
    .ready (ready),
    .dz    (dz)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic [15:0] aa, input logic [15:0] bb,
                                 input logic sg, input int now);
    exp_t e;
    int   sa, sd, qq, rr;
    e.due = now + ((bb == 16'd0) ? 1 : 18);
    if (bb == 16'd0) begin
      e.q  = 16'hFFFF;
      e.r  = aa;
      e.dz = 1'b1;
    end else if (sg) begin
      sa   = int'($signed(aa));
      sd   = int'($signed(bb));
      qq   = sa / sd;
      rr   = sa % sd;
      e.q  = qq[15:0];
      e.r  = rr[15:0];
      e.dz = 1'b0;
    end else begin
      e.q  = aa / bb;
      e.r  = aa % bb;
      e.dz = 1'b0;
    end
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (ready) begin
      if (sb.size() == 0) begin
        check("spurious_ready", {31'd0, ready}, 32'd0);
      end else begin
        e = sb.pop_front();
        check("q", {16'd0, q}, {16'd0, e.q});
        check("r", {16'd0, r}, {16'd0, e.r});
        check("dz", {31'd0, dz}, {31'd0, e.dz});
        check("ready_cycle", cyc, e.due);
        check("busy_at_ready", {31'd0, busy}, 32'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [15:0] aa, input logic [15:0] bb, input logic sg);
    a     = aa;
    b     = bb;
    sgn   = sg;
    start = 1'b1;
    if (!busy) sb.push_back(model(aa, bb, sg, cyc));
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sb.size() != 0 || busy) && n < 200) begin
      tick();
      n++;
    end
    check("idle_timeout", {31'd0, (n < 200)}, 32'd1);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!ready && n < 60) begin
      tick();
      n++;
    end
    check("ready_timeout", {31'd0, ready}, 32'd1);
  endtask

  initial begin
    int          bc;
    bit          seen;
    logic [15:0] ra;
    logic [15:0] rb;

    rst   = 1'b1;
    start = 1'b0;
    sgn   = 1'b0;
    a     = '0;
    b     = '0;
    tick();
    tick();
    check("rst_q", {16'd0, q}, 32'd0);
    check("rst_r", {16'd0, r}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_ready", {31'd0, ready}, 32'd0);
    check("rst_dz", {31'd0, dz}, 32'd0);
    rst = 1'b0;
    tick();

    // Basic 100/7 with busy-window count.
    issue(16'd100, 16'd7, 1'b0);
    bc   = 0;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (ready) seen = 1;
      else begin
        if (busy) bc++;
        tick();
      end
    end
    check("busy_cycles", bc, 32'd17);
    check("ready_seen", {31'd0, seen}, 32'd1);
    wait_idle();

    issue(16'hFFFF, 16'd1, 1'b0);
    wait_idle();
    issue(16'd3, 16'd10, 1'b0);
    wait_idle();

    // Divide by zero: immediate ready, no busy.
    issue(16'd5, 16'd0, 1'b0);
    check("dz_busy", {31'd0, busy}, 32'd0);
    check("dz_ready", {31'd0, ready}, 32'd1);
    tick();
    check("dz_busy_after", {31'd0, busy}, 32'd0);
    check("dz_ready_after", {31'd0, ready}, 32'd0);
    wait_idle();

    // Starts while busy are ignored; start in DONE chains back-to-back.
    issue(16'd100, 16'd7, 1'b0);
    repeat (4) tick();
    issue(16'd1, 16'd1, 1'b0);
    repeat (6) tick();
    issue(16'd2, 16'd3, 1'b0);
    wait_ready();
    issue(16'd200, 16'd9, 1'b0);
    wait_idle();

    // Reset in cycle 8 aborts the division.
    issue(16'd100, 16'd7, 1'b0);
    repeat (7) tick();
    rst = 1'b1;
    sb.delete();
    tick();
    rst = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_q", {16'd0, q}, 32'd0);
    check("abort_r", {16'd0, r}, 32'd0);
    check("abort_ready", {31'd0, ready}, 32'd0);
    repeat (25) tick();
    issue(16'd200, 16'd9, 1'b0);
    wait_idle();

    for (int i = 0; i < 10; i++) begin
      ra = 16'($urandom_range(0, 65535));
      rb = (i % 4 == 3) ? 16'd0 :
           (i % 2 == 0) ? 16'($urandom_range(1, 300)) : 16'($urandom_range(1, 65535));
      issue(ra, rb, 1'b0);
      wait_idle();
    end

`ifdef DIV16_SIGNED_EN
    issue(16'hFF9C, 16'd7, 1'b1);
    wait_idle();
    issue(16'h8000, 16'hFFFF, 1'b1);
    wait_idle();
    issue(16'hFF9C, 16'd0, 1'b1);
    wait_idle();
    issue(16'hFF9C, 16'd7, 1'b0);
    wait_idle();
    for (int i = 0; i < 8; i++) begin
      ra = 16'($urandom_range(0, 65535));
      rb = 16'($urandom_range(1, 65535));
      issue(ra, rb, 1'b1);
      wait_idle();
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
